// File: rtl/conv_line_buffer.sv
// ---------------------------------------------------------------------------
// conv_line_buffer
//
// Producer side of the 3x3 convolution stage. Incoming pixels are stored in
// four rotating line banks. For every accepted pixel the block emits a
// vertically aligned column of three pixels from the three previously
// completed lines at the same column.
//
// Ports:
//   clk_in          - system clock
//   rst_in          - asynchronous active-low reset
//   data_valid_in   - pixel/hcount/vcount valid this cycle
//   pixel_data_in   - incoming pixel (RGB565 by default)
//   hcount_in       - column of the incoming pixel
//   vcount_in       - line of the incoming pixel
//   data_valid_out  - line_buffer_out valid (2 cycles after acceptance)
//   line_buffer_out - [0]=line v-1, [1]=line v-2, [2]=line v-3
//   hcount_out      - hcount_in delayed by 2 cycles
//   vcount_out      - vcount_in delayed by 2 cycles
// ---------------------------------------------------------------------------
module conv_line_buffer #(
  parameter int HRES        = 320,
  parameter int VRES        = 240,
  parameter int PIXEL_WIDTH = 16
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        data_valid_in,
  input  logic [PIXEL_WIDTH-1:0]      pixel_data_in,
  input  logic [10:0]                 hcount_in,
  input  logic [9:0]                  vcount_in,
  output logic                        data_valid_out,
  output logic [2:0][PIXEL_WIDTH-1:0] line_buffer_out,
  output logic [10:0]                 hcount_out,
  output logic [9:0]                  vcount_out
);

  localparam int          AW       = (HRES > 1) ? $clog2(HRES) : 1;
  localparam logic [10:0] HRES_W   = 11'(HRES);
  localparam logic [10:0] LAST_COL = 11'(HRES - 1);

  // hcount is 11 bits wide, so a line cannot be longer than 2048 pixels.
  generate
    if (HRES < 1 || HRES > 2048 || VRES < 1) begin : g_param_check
      $error("conv_line_buffer: HRES must be 1..2048 and VRES must be >= 1");
    end
  endgenerate

  logic          accept;
  logic          rotate;
  logic [AW-1:0] addr;

  assign accept = data_valid_in && (hcount_in < HRES_W);
  assign rotate = accept && (hcount_in == LAST_COL);
  assign addr   = hcount_in[AW-1:0];

  // ---------------------------------------------------------------------
  // Bank rotation and fill tracking. The last pixel of a line is still
  // written with the old select; the new select applies from the next cycle.
  // A bank counts as filled once the write pointer moves away from it.
  // ---------------------------------------------------------------------
  logic [1:0] wr_sel_q, wr_sel_d;
  logic [3:0] filled_q, filled_d;

  always_comb begin
    wr_sel_d = wr_sel_q;
    filled_d = filled_q;
    if (rotate) begin
      wr_sel_d           = wr_sel_q + 2'd1;
      filled_d[wr_sel_q] = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_sel_q <= 2'd0;
      filled_q <= 4'd0;
    end else begin
      wr_sel_q <= wr_sel_d;
      filled_q <= filled_d;
    end
  end

  // ---------------------------------------------------------------------
  // Line banks. Contents are never reset; stale data is hidden by the
  // filled mask. The bank being written is also read, but its data is
  // never selected for output.
  // ---------------------------------------------------------------------
  logic [PIXEL_WIDTH-1:0] bank_rd [4];

  for (genvar b = 0; b < 4; b++) begin : g_bank
    logic [PIXEL_WIDTH-1:0] bank_mem [HRES];
    logic [PIXEL_WIDTH-1:0] rd_q;

    always_ff @(posedge clk_in) begin
      if (accept && (wr_sel_q == 2'(b))) begin
        bank_mem[addr] <= pixel_data_in;
      end
      if (accept) begin
        rd_q <= bank_mem[addr];
      end
    end

    assign bank_rd[b] = rd_q;
  end

  // ---------------------------------------------------------------------
  // Source bank and mask for each lane are frozen at issue time so that a
  // rotation on the same cycle cannot redirect reads already in flight.
  // ---------------------------------------------------------------------
  logic [2:0][1:0] src_d;
  logic [2:0]      mask_d;

  always_comb begin
    src_d  = '0;
    mask_d = '0;
    for (int k = 0; k < 3; k++) begin
      src_d[k]  = wr_sel_q - 2'(k + 1);
      mask_d[k] = filled_q[src_d[k]];
    end
  end

  logic            valid1_q;
  logic [10:0]     hcount1_q;
  logic [9:0]      vcount1_q;
  logic [2:0][1:0] src1_q;
  logic [2:0]      mask1_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid1_q  <= 1'b0;
      hcount1_q <= 11'd0;
      vcount1_q <= 10'd0;
      src1_q    <= '0;
      mask1_q   <= '0;
    end else begin
      valid1_q  <= accept;
      hcount1_q <= hcount_in;
      vcount1_q <= vcount_in;
      src1_q    <= src_d;
      mask1_q   <= mask_d;
    end
  end

  // Lane select and masking on the bank read data.
  logic [2:0][PIXEL_WIDTH-1:0] lane_d;

  always_comb begin
    lane_d = '0;
    for (int k = 0; k < 3; k++) begin
      lane_d[k] = mask1_q[k] ? bank_rd[src1_q[k]] : '0;
    end
  end

  // ---------------------------------------------------------------------
  // Output register. The pixel column only updates with a valid read so
  // the consumer sees the last column held through input gaps.
  // ---------------------------------------------------------------------
  logic                        data_valid_q;
  logic [2:0][PIXEL_WIDTH-1:0] lanes_q;
  logic [10:0]                 hcount_q;
  logic [9:0]                  vcount_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      data_valid_q <= 1'b0;
      lanes_q      <= '0;
      hcount_q     <= 11'd0;
      vcount_q     <= 10'd0;
    end else begin
      data_valid_q <= valid1_q;
      hcount_q     <= hcount1_q;
      vcount_q     <= vcount1_q;
      if (valid1_q) begin
        lanes_q <= lane_d;
      end
    end
  end

  assign data_valid_out  = data_valid_q;
  assign line_buffer_out = lanes_q;
  assign hcount_out      = hcount_q;
  assign vcount_out      = vcount_q;

endmodule
